// File: rtl/manchester_pkg.sv
// rtl/manchester_pkg.sv - shared FSM type and bit-phase constants for the Manchester receiver
package manchester_pkg;

    localparam int SPB_DEFAULT = 8;

    typedef enum logic [1:0] {
        ST_IDLE  = 2'd0,
        ST_START = 2'd1,
        ST_DATA  = 2'd2
    } state_e;

    // first-half sample point within a bit period
    function automatic int spb_quarter(input int spb);
        return spb / 4;
    endfunction

    // mid-bit point, where the guaranteed Manchester transition sits
    function automatic int spb_half(input int spb);
        return spb / 2;
    endfunction

    // second-half sample point within a bit period
    function automatic int spb_three_quarter(input int spb);
        return (3 * spb) / 4;
    endfunction

endpackage

// File: rtl/manchester_sync.sv
// rtl/manchester_sync.sv - two-flop synchroniser for the asynchronous Manchester line
module manchester_sync (
    input  logic clk,
    input  logic rst,
    input  logic d,
    output logic q
);

    logic meta_q;
    logic sync_q;

    // two-stage capture of the asynchronous input
    always_ff @(posedge clk) begin
        if (rst) begin
            meta_q <= 1'b0;
            sync_q <= 1'b0;
        end else begin
            meta_q <= d;
            sync_q <= meta_q;
        end
    end

    assign q = sync_q;

endmodule

// File: rtl/manchester_rx.sv
// rtl/manchester_rx.sv - Manchester (IEEE 802.3) byte receiver with mid-bit resynchronisation
module manchester_rx
    import manchester_pkg::*;
#(
    parameter int SPB = SPB_DEFAULT
) (
    input  logic       clk,
    input  logic       rst,
    input  logic       din,
    output logic [7:0] out_data,
    output logic       out_valid,
    input  logic       out_ready,
    output logic       err_code,
    output logic       err_overrun,
    output logic       busy
);

    localparam int            PW      = $clog2(SPB);
    localparam logic [PW-1:0] PH_Q    = PW'(spb_quarter(SPB));
    localparam logic [PW-1:0] PH_SYNC = PW'(spb_half(SPB) + 1);
    localparam logic [PW-1:0] PH_3Q   = PW'(spb_three_quarter(SPB));
    localparam logic [PW-1:0] PH_LAST = PW'(SPB - 1);

    logic          rx;
    logic          rx_d_q;
    logic          edge_seen;
    logic          rise;

    state_e        state_q, state_d;
    logic [PW-1:0] phase_q, phase_d;
    logic [PW-1:0] phase_inc;
    logic [2:0]    bit_cnt_q, bit_cnt_d;
    logic          h1_q, h1_d;
    logic [7:0]    shreg_q, shreg_d;
    logic [7:0]    out_data_q, out_data_d;
    logic          out_valid_q, out_valid_d;
    logic          err_code_q, err_code_d;
    logic          err_overrun_q, err_overrun_d;
    logic [7:0]    byte_done;

    manchester_sync u_sync (
        .clk (clk),
        .rst (rst),
        .d   (din),
        .q   (rx)
    );

    assign edge_seen = rx ^ rx_d_q;
    assign rise      = rx & ~rx_d_q;
    assign phase_inc = (phase_q == PH_LAST) ? '0 : phase_q + PW'(1);

    // state and datapath registers
    always_ff @(posedge clk) begin
        if (rst) begin
            rx_d_q        <= 1'b0;
            state_q       <= ST_IDLE;
            phase_q       <= '0;
            bit_cnt_q     <= 3'd0;
            h1_q          <= 1'b0;
            shreg_q       <= 8'h00;
            out_data_q    <= 8'h00;
            out_valid_q   <= 1'b0;
            err_code_q    <= 1'b0;
            err_overrun_q <= 1'b0;
        end else begin
            rx_d_q        <= rx;
            state_q       <= state_d;
            phase_q       <= phase_d;
            bit_cnt_q     <= bit_cnt_d;
            h1_q          <= h1_d;
            shreg_q       <= shreg_d;
            out_data_q    <= out_data_d;
            out_valid_q   <= out_valid_d;
            err_code_q    <= err_code_d;
            err_overrun_q <= err_overrun_d;
        end
    end

    // next-state: start detection, half-bit sampling, resync and byte handoff
    always_comb begin
        state_d       = state_q;
        phase_d       = phase_inc;
        bit_cnt_d     = bit_cnt_q;
        h1_d          = h1_q;
        shreg_d       = shreg_q;
        out_data_d    = out_data_q;
        out_valid_d   = out_valid_q;
        err_code_d    = 1'b0;
        err_overrun_d = 1'b0;
        byte_done     = shreg_q;
        byte_done[bit_cnt_q] = rx;

        // a completed handshake frees the output register
        if (out_valid_q && out_ready) begin
            out_valid_d = 1'b0;
        end

        case (state_q)
            ST_IDLE: begin
                phase_d = '0;
                // the start bit's rising edge is its mid-bit point
                if (rise) begin
                    state_d = ST_START;
                    phase_d = PH_SYNC;
                end
            end

            ST_START: begin
                if (phase_q == PH_3Q) begin
                    if (rx) begin
                        state_d   = ST_DATA;
                        bit_cnt_d = 3'd0;
                    end else begin
                        state_d = ST_IDLE;
                    end
                end
            end

            ST_DATA: begin
                // only mid-bit transitions realign the phase; boundary edges are ignored
                if (edge_seen && (phase_q > PH_Q) && (phase_q < PH_3Q)) begin
                    phase_d = PH_SYNC;
                end
                if (phase_q == PH_Q) begin
                    h1_d = rx;
                end
                if (phase_q == PH_3Q) begin
                    if (h1_q == rx) begin
                        err_code_d = 1'b1;
                        shreg_d    = 8'h00;
                        bit_cnt_d  = 3'd0;
                        state_d    = ST_IDLE;
                    end else if (bit_cnt_q == 3'd7) begin
                        shreg_d   = 8'h00;
                        bit_cnt_d = 3'd0;
                        state_d   = ST_IDLE;
                        if (!out_valid_q || out_ready) begin
                            out_data_d  = byte_done;
                            out_valid_d = 1'b1;
                        end else begin
                            err_overrun_d = 1'b1;
                        end
                    end else begin
                        shreg_d   = byte_done;
                        bit_cnt_d = bit_cnt_q + 3'd1;
                    end
                end
            end

            default: begin
                state_d = ST_IDLE;
            end
        endcase
    end

    assign out_data    = out_data_q;
    assign out_valid   = out_valid_q;
    assign err_code    = err_code_q;
    assign err_overrun = err_overrun_q;
    assign busy        = (state_q != ST_IDLE);

endmodule

// File: tb/tb_manchester_rx.sv
// tb/tb_manchester_rx.sv - self-checking bench for manchester_rx
module tb_manchester_rx;

    localparam int SPB = 8;

    logic       clk = 1'b0;
    logic       rst;
    logic       din;
    logic       out_ready;
    logic [7:0] out_data;
    logic       out_valid;
    logic       err_code;
    logic       err_overrun;
    logic       busy;

    manchester_rx #(.SPB(SPB)) dut (
        .clk         (clk),
        .rst         (rst),
        .din         (din),
        .out_data    (out_data),
        .out_valid   (out_valid),
        .out_ready   (out_ready),
        .err_code    (err_code),
        .err_overrun (err_overrun),
        .busy        (busy)
    );

    always #5 clk = ~clk;

    int cyc = 0;
    always @(posedge clk) cyc = cyc + 1;

    // event monitor: counts pulses and records every delivered byte
    int         n_code = 0;
    int         n_ovr = 0;
    int         n_vrise = 0;
    int         n_busy = 0;
    int         vrise_cyc = 0;
    logic       prev_valid = 1'b0;
    logic [7:0] got_q[$];

    always @(negedge clk) begin
        if (err_code === 1'b1) n_code++;
        if (err_overrun === 1'b1) n_ovr++;
        if (busy === 1'b1) n_busy++;
        if (out_valid === 1'b1 && prev_valid !== 1'b1) begin
            n_vrise++;
            vrise_cyc = cyc;
        end
        if (out_valid === 1'b1 && out_ready === 1'b1) got_q.push_back(out_data);
        prev_valid = out_valid;
    end

    int checks = 0;
    int passed = 0;
    int fails = 0;
    int g0, c0, o0, v0, b0;
    int t7;
    logic [7:0] exp_q[$];
    int exp_code;

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        assert (obs === exp) passed++;
        else begin
            fails++;
            $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
        end
    endtask

    task automatic snap();
        g0 = got_q.size();
        c0 = n_code;
        o0 = n_ovr;
        v0 = n_vrise;
        b0 = n_busy;
    endtask

    task automatic hold(input logic lvl, input int n);
        for (int i = 0; i < n; i++) begin
            @(posedge clk);
            #2;
            din = lvl;
        end
    endtask

    // 1 = low-then-high, 0 = high-then-low; bad >= 0 flattens that bit and ends the frame there
    task automatic send_frame(input logic [7:0] b, input int per, input int bad, input int nbits, output int tb7);
        int h1;
        int h2;
        h1 = per / 2;
        h2 = per - h1;
        tb7 = 0;
        hold(1'b0, h1);
        hold(1'b1, h2);
        for (int i = 0; i < nbits; i++) begin
            if (i == bad) begin
                hold(1'b0, per);
                break;
            end
            hold(~b[i], h1);
            if (i == 7) tb7 = cyc + 1;
            hold(b[i], h2);
        end
    endtask

    initial begin
        #1_000_000;
        $display("FAIL watchdog: simulation did not finish in time");
        $fatal(1, "watchdog");
    end

    initial begin
        rst = 1'b1;
        din = 1'b0;
        out_ready = 1'b0;
        repeat (3) @(posedge clk);
        #2;
        check("rst_out_data", out_data, 8'h00);
        check("rst_out_valid", out_valid, 1'b0);
        check("rst_err_code", err_code, 1'b0);
        check("rst_err_overrun", err_overrun, 1'b0);
        check("rst_busy", busy, 1'b0);
        rst = 1'b0;
        hold(1'b0, SPB);

        // single byte, consumer always ready; valid rises 2 sync + 2 phase + 1 reg after bit 7 mid
        out_ready = 1'b1;
        snap();
        send_frame(8'hA5, SPB, -1, 8, t7);
        hold(1'b0, 2 * SPB);
        check("a5_valid_pulses", n_vrise - v0, 1);
        check("a5_got_count", got_q.size() - g0, 1);
        check("a5_data", got_q[$], 8'hA5);
        check("a5_latency", vrise_cyc - t7, 5);
        check("a5_no_code_err", n_code - c0, 0);
        check("a5_no_overrun", n_ovr - o0, 0);
        check("a5_valid_cleared", out_valid, 1'b0);
        check("a5_idle", busy, 1'b0);

        // back-to-back frames with consumer stalled: first byte held, second dropped
        out_ready = 1'b0;
        snap();
        send_frame(8'h00, SPB, -1, 8, t7);
        send_frame(8'hFF, SPB, -1, 8, t7);
        hold(1'b0, 2 * SPB);
        check("ovr_valid_held", out_valid, 1'b1);
        check("ovr_data_held", out_data, 8'h00);
        check("ovr_pulse_once", n_ovr - o0, 1);
        check("ovr_one_load", n_vrise - v0, 1);
        @(posedge clk);
        #2 out_ready = 1'b1;
        @(posedge clk);
        #2 out_ready = 1'b0;
        hold(1'b0, 2);
        check("ovr_release_clears", out_valid, 1'b0);
        check("ovr_release_count", got_q.size() - g0, 1);
        check("ovr_release_data", got_q[$], 8'h00);

        // ready arrives in the very cycle the next byte completes: swap, no overrun
        snap();
        send_frame(8'h11, SPB, -1, 8, t7);
        hold(1'b0, SPB);
        send_frame(8'h6E, SPB, -1, 8, t7);
        @(posedge clk);
        #2 out_ready = 1'b1;
        @(posedge clk);
        #2 out_ready = 1'b0;
        hold(1'b0, 2);
        check("swap_valid", out_valid, 1'b1);
        check("swap_data", out_data, 8'h6E);
        check("swap_no_overrun", n_ovr - o0, 0);
        check("swap_old_taken", got_q[$], 8'h11);
        out_ready = 1'b1;
        hold(1'b0, SPB);
        check("swap_new_taken", got_q[$], 8'h6E);
        check("swap_count", got_q.size() - g0, 2);

        // code violation on data bit 3, then a clean retry
        snap();
        send_frame(8'h3C, SPB, 3, 8, t7);
        hold(1'b0, 2 * SPB);
        check("viol_code_pulse", n_code - c0, 1);
        check("viol_no_valid", n_vrise - v0, 0);
        check("viol_out_valid", out_valid, 1'b0);
        check("viol_idle", busy, 1'b0);
        send_frame(8'h3C, SPB, -1, 8, t7);
        hold(1'b0, 2 * SPB);
        check("viol_retry_count", got_q.size() - g0, 1);
        check("viol_retry_data", got_q[$], 8'h3C);
        check("viol_retry_no_err", n_code - c0, 1);

        // slow transmitter: 9 clocks per bit
        snap();
        send_frame(8'h5A, 9, -1, 8, t7);
        hold(1'b0, 2 * SPB);
        check("slow_count", got_q.size() - g0, 1);
        check("slow_data", got_q[$], 8'h5A);
        check("slow_no_err", n_code - c0, 0);

        // short high glitch on an idle line
        snap();
        hold(1'b1, 2);
        hold(1'b0, 3 * SPB);
        check("glitch_busy_seen", (n_busy - b0) != 0, 1'b1);
        check("glitch_busy_low", busy, 1'b0);
        check("glitch_no_valid", n_vrise - v0, 0);
        check("glitch_no_err", n_code - c0, 0);

        // reset in the middle of a frame
        snap();
        send_frame(8'hC3, SPB, -1, 4, t7);
        @(posedge clk);
        #2;
        rst = 1'b1;
        din = 1'b0;
        repeat (3) @(posedge clk);
        #2;
        check("midrst_out_data", out_data, 8'h00);
        check("midrst_out_valid", out_valid, 1'b0);
        check("midrst_busy", busy, 1'b0);
        check("midrst_err_code", err_code, 1'b0);
        check("midrst_err_overrun", err_overrun, 1'b0);
        rst = 1'b0;
        hold(1'b0, SPB);
        check("midrst_no_pulses", (n_code - c0) + (n_ovr - o0) + (n_vrise - v0), 0);
        send_frame(8'hC3, SPB, -1, 8, t7);
        hold(1'b0, 2 * SPB);
        check("midrst_retry_count", got_q.size() - g0, 1);
        check("midrst_retry_data", got_q[$], 8'hC3);

        // random frames: lengths 8/9, random gaps, occasional flattened bit
        snap();
        exp_code = 0;
        for (int f = 0; f < 8; f++) begin
            logic [7:0] rb;
            int per;
            int bad;
            rb  = 8'($urandom_range(0, 255));
            per = ($urandom_range(0, 1) == 1) ? 9 : 8;
            bad = ($urandom_range(0, 3) == 0) ? int'($urandom_range(0, 7)) : -1;
            send_frame(rb, per, bad, 8, t7);
            if (bad < 0) exp_q.push_back(rb);
            else exp_code++;
            hold(1'b0, int'($urandom_range(0, 2)) * SPB);
        end
        hold(1'b0, 3 * SPB);
        check("rand_count", got_q.size() - g0, exp_q.size());
        check("rand_code_errs", n_code - c0, exp_code);
        check("rand_no_overrun", n_ovr - o0, 0);
        for (int k = 0; k < exp_q.size(); k++) begin
            if (g0 + k < got_q.size()) check("rand_byte", got_q[g0 + k], exp_q[k]);
        end

        $display("%0d/%0d checks passed", passed, checks);
        $finish;
    end

endmodule
